// File: rtl/acct_cfg_master.sv
// AXI-lite initiator that snapshots the access-control table and writes it entry by entry.
// Define ACCT_CFG_VERIFY_EN to add a read-back pass that compares each entry after the writes.
module acct_cfg_master #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter int unsigned           NUM_ENTRIES = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [NUM_ENTRIES*32-1:0] cfg_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [7:0]                err_idx_o,
  output logic                      aw_valid_o,
  output logic [ADDR_WIDTH-1:0]     aw_addr_o,
  input  logic                      aw_ready_i,
  output logic                      w_valid_o,
  output logic [DATA_WIDTH-1:0]     w_data_o,
  output logic [DATA_WIDTH/8-1:0]   w_strb_o,
  input  logic                      w_ready_i,
  input  logic                      b_valid_i,
  input  logic [1:0]                b_resp_i,
  output logic                      b_ready_o,
  output logic                      ar_valid_o,
  output logic [ADDR_WIDTH-1:0]     ar_addr_o,
  input  logic                      ar_ready_i,
  input  logic                      r_valid_i,
  input  logic [DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                r_resp_i,
  output logic                      r_ready_o
);

  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned SNAP_W  = NUM_ENTRIES * ENTRY_W;
  localparam int unsigned IDX_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [1:0]       RESP_OKAY = 2'b00;

`ifdef ACCT_CFG_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, WRESP, DONE} state_t;
`endif

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [SNAP_W-1:0]   snap;
  logic [SNAP_W-1:0]   snap_rot;
  logic                aw_done;
  logic                w_done;

  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_WIDTH'({i, 3'b000});
  endfunction

  // The snapshot rotates one entry per advance so the current entry is always in bits [31:0];
  // after NUM_ENTRIES advances it is back at entry 0 for the read-back pass.
  assign snap_rot = (snap >> ENTRY_W) | (snap << (ENTRY_W * (NUM_ENTRIES - 1)));
  assign idx_nxt  = idx + IDX_W'(1);
  assign aw_done  = !aw_valid_o || aw_ready_i;
  assign w_done   = !w_valid_o || w_ready_i;

`ifdef ACCT_CFG_VERIFY_EN
  logic rd_err;
  logic unused_rdata;
  assign rd_err       = (r_resp_i != RESP_OKAY) || (r_data_i[ENTRY_W-1:0] != snap[ENTRY_W-1:0]);
  assign ar_addr_o    = aw_addr_o;
  assign unused_rdata = ^r_data_i[DATA_WIDTH-1:ENTRY_W];
`else
  logic unused_rd;
  assign ar_valid_o = 1'b0;
  assign ar_addr_o  = '0;
  assign r_ready_o  = 1'b0;
  assign unused_rd  = ^{ar_ready_i, r_valid_i, r_data_i, r_resp_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      snap       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_idx_o  <= '0;
      aw_valid_o <= 1'b0;
      aw_addr_o  <= '0;
      w_valid_o  <= 1'b0;
      w_data_o   <= '0;
      w_strb_o   <= '0;
      b_ready_o  <= 1'b0;
`ifdef ACCT_CFG_VERIFY_EN
      ar_valid_o <= 1'b0;
      r_ready_o  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            snap       <= cfg_data_i;
            idx        <= '0;
            busy_o     <= 1'b1;
            error_o    <= 1'b0;
            err_idx_o  <= '0;
            aw_valid_o <= 1'b1;
            aw_addr_o  <= BASE_ADDR;
            w_valid_o  <= 1'b1;
            w_data_o   <= DATA_WIDTH'(cfg_data_i[ENTRY_W-1:0]);
            w_strb_o   <= '1;
            state      <= WR;
          end
        end
        WR: begin
          // AW and W retire independently; leave once both have been accepted
          if (aw_ready_i) aw_valid_o <= 1'b0;
          if (w_ready_i)  w_valid_o  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_o <= 1'b1;
            state     <= WRESP;
          end
        end
        WRESP: begin
          if (b_valid_i) begin
            b_ready_o <= 1'b0;
            if (b_resp_i != RESP_OKAY) begin
              error_o   <= 1'b1;
              err_idx_o <= idx;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= DONE;
            end else if (idx == LAST_IDX) begin
`ifdef ACCT_CFG_VERIFY_EN
              snap       <= snap_rot;
              idx        <= '0;
              aw_addr_o  <= BASE_ADDR;
              ar_valid_o <= 1'b1;
              state      <= RD;
`else
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
`endif
            end else begin
              snap       <= snap_rot;
              idx        <= idx_nxt;
              aw_addr_o  <= entry_addr(idx_nxt);
              w_data_o   <= DATA_WIDTH'(snap_rot[ENTRY_W-1:0]);
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
              state      <= WR;
            end
          end
        end
`ifdef ACCT_CFG_VERIFY_EN
        RD: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            state      <= RDATA;
          end
        end
        RDATA: begin
          if (r_valid_i) begin
            r_ready_o <= 1'b0;
            if (rd_err) begin
              error_o   <= 1'b1;
              err_idx_o <= idx;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= DONE;
            end else if (idx == LAST_IDX) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              snap       <= snap_rot;
              idx        <= idx_nxt;
              aw_addr_o  <= entry_addr(idx_nxt);
              ar_valid_o <= 1'b1;
              state      <= RD;
            end
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acct_cfg_master.md
Name: acct_cfg_master

Overview:
- AXI-lite initiator that programs the access-control table over the peripheral bus after boot or on software request.
- On a start pulse it snapshots a table of NUM_ENTRIES 32-bit policy words, writes each one to BASE_ADDR + 8*k, and collects every write response.
- With the optional feature compiled in, it also reads each entry back and compares it against the written value.
- Sits on the initiator side of the crossbar, facing the access-control register slave.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width; must be 64.
- NUM_ENTRIES, 10, number of 32-bit entries written; range 1..256.
- BASE_ADDR, 64'h0, byte address of entry 0.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle start request.
- cfg_data_i  in  NUM_ENTRIES*32  entry k is cfg_data_i[32k+:32].
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when the sequence ends.
- error_o  out  1  sticky error flag; cleared by the next accepted start.
- err_idx_o  out  8  index of the first failing entry.
- aw_valid_o  out  1  write address valid.
- aw_addr_o  out  ADDR_WIDTH  write address.
- aw_ready_i  in  1  write address ready.
- w_valid_o  out  1  write data valid.
- w_data_o  out  DATA_WIDTH  write data.
- w_strb_o  out  DATA_WIDTH/8  write strobes.
- w_ready_i  in  1  write data ready.
- b_valid_i  in  1  write response valid.
- b_resp_i  in  2  write response code.
- b_ready_o  out  1  write response ready.
- ar_valid_o  out  1  read address valid.
- ar_addr_o  out  ADDR_WIDTH  read address.
- ar_ready_i  in  1  read address ready.
- r_valid_i  in  1  read data valid.
- r_data_i  in  DATA_WIDTH  read data.
- r_resp_i  in  2  read response code.
- r_ready_o  out  1  read data ready.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, FSM in IDLE, index 0, snapshot cleared.
- Interrupted transfers are abandoned; the interconnect shares this reset.
- FSM states: IDLE, WR, WRESP, RD, RDATA, DONE.
- IDLE:
  - start_i=1 captures cfg_data_i into an internal snapshot, clears error_o/err_idx_o, sets idx=0, busy_o=1, and enters WR on the next cycle.
  - start_i while busy_o=1 is ignored.
- WR:
  - aw_valid_o and w_valid_o assert in the same cycle.
  - aw_addr_o = BASE_ADDR + {idx,3'b000}.
  - w_data_o = {32'h0, snapshot[idx]}; w_strb_o = all ones.
  - Each valid stays high until its own ready is sampled high and then drops independently. AW and W may complete in either order or in the same cycle.
  - Address and data are held stable while valid is high.
  - Go to WRESP once both handshakes have completed.
- WRESP:
  - b_ready_o=1.
  - On b_valid_i with b_resp_i!=2'b00: set error_o, err_idx_o=idx, go to DONE.
  - On OKAY with idx==NUM_ENTRIES-1: go to RD if verify is enabled (idx reset to 0), otherwise go to DONE.
  - On OKAY otherwise: idx+1, back to WR.
- RD:
  - ar_valid_o=1, ar_addr_o = BASE_ADDR + {idx,3'b000}, held until ar_ready_i.
  - Then go to RDATA.
- RDATA:
  - r_ready_o=1.
  - On r_valid_i, an error is r_resp_i!=OKAY or r_data_i[31:0]!=snapshot[idx]. A read-locked entry returns 0; a write-locked entry keeps its old value.
  - On error: set error_o, record idx, go to DONE.
  - On the last entry: go to DONE. Otherwise idx+1, back to RD.
- DONE: done_o=1 for exactly one cycle, busy_o=0, return to IDLE. error_o and err_idx_o hold.
- At most one outstanding transaction at a time; no bursts. The upper 32 bits of r_data_i are ignored.
- idx width is 8 bits; it never exceeds NUM_ENTRIES-1, so no wrap.
- Minimum per-write latency with ready/valid tied high: WR 1 cycle + WRESP 1 cycle.
- Start-to-done for N entries, no verify, zero-wait slave: 2N+1 cycles after the start cycle.

Optional Feature:
- Macro: ACCT_CFG_VERIFY_EN.
- Defined: the RD/RDATA readback phase runs after all writes, as described above.
- Undefined:
  - RD and RDATA are not built.
  - ar_valid_o and r_ready_o are tied to 0; ar_addr_o is tied to 0.
  - The sequence ends after the last write response.

Test Plan:
- Zero-wait slave, NUM_ENTRIES=10, entries 0xA5A50000+k:
  - 10 writes land at addresses 0x00..0x48 with w_data=0x00000000_A5A5000k and strb 0xFF.
  - done_o pulses 21 cycles after start; error_o=0.
- Random ready delays, including aw_ready before w_ready, the reverse, and both together:
  - Each AW and W is issued exactly once per entry and held stable while stalled.
  - Final slave contents equal the snapshot.
- b_resp=2'b10 on entry 3:
  - No AW is issued for entry 4; error_o=1, err_idx_o=3, one done_o pulse.
- VERIFY_EN, slave write-locks entries 6..8 (pre-reset value 0xFFFFFFFF):
  - Readback of entry 6 mismatches; error_o=1, err_idx_o=6.
- Reset asserted mid-WR on entry 5:
  - All valids and busy_o drop asynchronously.
  - A new start re-runs from entry 0 with error_o cleared.
- start_i pulsed again while busy:
  - Ignored: the sequence runs once and the cfg_data_i change is not sampled.
